sync_fifo_ctrl: RTL and testbench
=================================

SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, giving depth DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter AFULL_THRESH, default DEPTH-4, almost_full asserts when count >= AFULL_THRESH.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 4, almost_empty asserts when count <= AEMPTY_THRESH.
REQ-005 Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wdata  in  DATA_WIDTH  write data.
- winc  in  1  write request.
- rinc  in  1  read request.
- err_clr  in  1  clears sticky error flags; present only with FIFO_ERR_FLAGS_EN.
- rdata  out  DATA_WIDTH  registered read data.
- wfull  out  1  FIFO holds DEPTH words.
- rempty  out  1  FIFO holds 0 words.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  ADDR_WIDTH+1  current fill level, 0..DEPTH.
- overflow  out  1  sticky write-when-full flag; present only with FIFO_ERR_FLAGS_EN.
- underflow  out  1  sticky read-when-empty flag; present only with FIFO_ERR_FLAGS_EN.

Function
REQ-006 Write accepted iff winc && !wfull at the edge; wdata stored at write address, write pointer increments.
REQ-007 Read accepted iff rinc && !rempty at the edge; rdata loads the word at read address on that edge (1-cycle latency), read pointer increments.
REQ-008 rdata SHALL hold its last value when no read is accepted.
REQ-009 Pointers are ADDR_WIDTH+1 bits binary; address = low ADDR_WIDTH bits; wrap from DEPTH-1 to 0 with MSB toggle.
REQ-010 wfull = (pointer MSBs differ) && (address bits equal); rempty = pointers equal; both registered-state derived, no combinational path from winc/rinc.
REQ-011 count = wptr - rptr modulo 2**(ADDR_WIDTH+1); +1 on write-only, -1 on read-only, unchanged on both or neither.
REQ-012 Simultaneous winc and rinc when empty: write accepted, read rejected; rempty deasserts next cycle.
REQ-013 Simultaneous winc and rinc when full: read accepted, write rejected; count becomes DEPTH-1.
REQ-014 Simultaneous accepted write and read otherwise: both proceed, count unchanged, flags unchanged.
REQ-015 almost_full/almost_empty SHALL be derived from count and update in the same cycle as count.
REQ-016 Rejected requests SHALL not modify pointers, memory or rdata.

Reset
REQ-017 On rst_n low, immediately: pointers 0, count 0, rdata 0, rempty 1, wfull 0, almost_empty 1, almost_full 0, overflow 0, underflow 0.
REQ-018 Reset mid-operation discards all contents; memory array contents need not be cleared.
REQ-019 Reset deassertion SHALL be synchronised externally; first access permitted on the first edge after release.

Configuration
REQ-020 Macro FIFO_ERR_FLAGS_EN defined: err_clr, overflow, underflow exist; overflow sets on winc && wfull, underflow sets on rinc && rempty; both hold until err_clr or reset; set has priority over err_clr in the same cycle.
REQ-021 FIFO_ERR_FLAGS_EN undefined: err_clr, overflow, underflow ports and logic absent; all other behaviour identical.

Verification
REQ-022 Reset, then DATA_WIDTH=32, ADDR_WIDTH=4: 16 writes of 0x1..0x10 -> wfull=1, count=16, almost_full from count 12.
REQ-023 Read 16 words -> rdata 0x1..0x10 in order, each one cycle after rinc; rempty=1, count=0, almost_empty from count 4.
REQ-024 When full, winc and rinc together -> rdata=oldest word, count=15, wfull=0, extra word not stored.
REQ-025 When empty, winc and rinc together with wdata=0xA5 -> count=1, rdata unchanged, next read returns 0xA5.
REQ-026 40 interleaved write/read cycles crossing pointer wrap twice -> data order preserved, count never exceeds 16.
REQ-027 With FIFO_ERR_FLAGS_EN: write when full -> overflow=1 next cycle, held; err_clr pulse -> 0; read when empty -> underflow=1; assert rst_n low mid-burst -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// sync_fifo_ctrl : single-clock FIFO with registered read data and level flags
// Optional sticky overflow/underflow flags under macro FIFO_ERR_FLAGS_EN.
// Revision: 1.0
// ============================================================================
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 8,
  parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  winc,
  input  logic                  rinc,
`ifdef FIFO_ERR_FLAGS_EN
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int                DEPTH    = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_AFULL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] C_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic w_full, w_empty, w_wr_en, w_rd_en;
  logic [ADDR_WIDTH:0] w_count;

  // Status comes purely from the pointer registers, so no request input
  // reaches a flag combinationally.
  assign w_full  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                   (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
  assign w_empty = (wptr_q == rptr_q);
  assign w_count = wptr_q - rptr_q;
  assign w_wr_en = winc && !w_full;
  assign w_rd_en = rinc && !w_empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    rdata_d = rdata_q;
    if (w_wr_en) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (w_rd_en) begin
      rptr_d  = rptr_q + 1'b1;
      rdata_d = mem[rptr_q[ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is intentionally not reset; stale words are unreachable once the
  // pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem[wptr_q[ADDR_WIDTH-1:0]] <= wdata;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A new error event wins over a clear arriving in the same cycle.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (winc && w_full) begin
      overflow_d = 1'b1;
    end else if (err_clr) begin
      overflow_d = 1'b0;
    end
    if (rinc && w_empty) begin
      underflow_d = 1'b1;
    end else if (err_clr) begin
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  assign rdata        = rdata_q;
  assign wfull        = w_full;
  assign rempty       = w_empty;
  assign count        = w_count;
  assign almost_full  = (w_count >= C_AFULL);
  assign almost_empty = (w_count <= C_AEMPTY);

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sync_fifo_ctrl : directed scoreboard bench for sync_fifo_ctrl (16 x 32)
// Revision: 1.0
// ============================================================================
module tb_sync_fifo_ctrl;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] wdata = '0;
  logic          winc = 1'b0;
  logic          rinc = 1'b0;
  logic [DW-1:0] rdata;
  logic          wfull, rempty, almost_full, almost_empty;
  logic [AW:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
  logic          err_clr = 1'b0;
  logic          overflow, underflow;
  logic          m_ov = 1'b0;
  logic          m_un = 1'b0;
`endif

  int            n_assert = 0;
  int            n_fail = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] m_rdata = '0;

  sync_fifo_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wdata       (wdata),
    .winc        (winc),
    .rinc        (rinc),
`ifdef FIFO_ERR_FLAGS_EN
    .err_clr     (err_clr),
    .overflow    (overflow),
    .underflow   (underflow),
`endif
    .rdata       (rdata),
    .wfull       (wfull),
    .rempty      (rempty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int lvl;
    lvl = sb.size();
    chk("count",        32'(count),        32'(lvl));
    chk("wfull",        32'(wfull),        32'(lvl == DEPTH));
    chk("rempty",       32'(rempty),       32'(lvl == 0));
    chk("almost_full",  32'(almost_full),  32'(lvl >= DEPTH - 4));
    chk("almost_empty", 32'(almost_empty), 32'(lvl <= 4));
    chk("rdata",        rdata,             m_rdata);
    chk("count_bound",  32'(count <= 5'(DEPTH)), 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow",     32'(overflow),     32'(m_ov));
    chk("underflow",    32'(underflow),    32'(m_un));
`endif
  endtask

  // One clock of stimulus; the scoreboard decides acceptance from its own
  // fill level before the edge, then everything is compared after the edge.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    logic wacc, racc;
    @(negedge clk);
    winc  = w;
    wdata = d;
    rinc  = r;
    wacc  = w && (sb.size() < DEPTH);
    racc  = r && (sb.size() > 0);
`ifdef FIFO_ERR_FLAGS_EN
    if (w && sb.size() == DEPTH) m_ov = 1'b1;
    else if (err_clr)            m_ov = 1'b0;
    if (r && sb.size() == 0)     m_un = 1'b1;
    else if (err_clr)            m_un = 1'b0;
`endif
    @(posedge clk);
    #1;
    if (racc) m_rdata = sb.pop_front();
    if (wacc) sb.push_back(d);
    check_all();
  endtask

  initial begin
    // Asynchronous reset, observed before any clock edge
    #2 rst_n = 1'b0;
    #1 check_all();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Fill to full, then a rejected write
    for (int i = 1; i <= DEPTH; i++) step(1'b1, DW'(i), 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0);

    // Simultaneous write+read when full: only the read proceeds
    step(1'b1, 32'hBAD0_0001, 1'b1);
    step(1'b1, 32'h11, 1'b0);

    // Drain completely, then a rejected read leaves rdata untouched
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);

    // Simultaneous write+read when empty: only the write proceeds
    step(1'b1, 32'hA5, 1'b1);
    step(1'b0, '0, 1'b1);

`ifdef FIFO_ERR_FLAGS_EN
    err_clr = 1'b1;
    step(1'b0, '0, 1'b0);
    err_clr = 1'b0;
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    err_clr = 1'b1;
    step(1'b0, '0, 1'b0);
    err_clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h400 + DW'(i), 1'b0);
    step(1'b1, 32'h4FF, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    err_clr = 1'b1;
    step(1'b1, 32'h4FE, 1'b0);
    step(1'b0, '0, 1'b0);
    err_clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
`endif

    // Interleaved traffic, write every cycle, read three of four: wraps twice
    for (int i = 0; i < 40; i++) step(1'b1, 32'h100 + DW'(i), (i % 4) != 0);

    // Reset asserted between edges while a burst is in flight
    step(1'b1, 32'h200, 1'b0);
    step(1'b1, 32'h201, 1'b0);
    @(negedge clk);
    winc  = 1'b1;
    wdata = 32'h202;
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    m_rdata = '0;
`ifdef FIFO_ERR_FLAGS_EN
    m_ov = 1'b0;
    m_un = 1'b0;
`endif
    check_all();
    winc = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step(1'b1, 32'h300, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
